// File: rtl/acq_event_reader.sv
// ---------------------------------------------------------------------------
// acq_event_reader
// Consumer end of the Acquisition Event FIFO. Pops one 32-bit event word at a
// time, validates format, trigger type and trigger-number continuity, then
// issues one readout request per valid event and waits for it to finish.
//
// Ports
//   clk, reset            40 MHz TTC clock, asynchronous active-high reset
//   chan_en[4:0]          channels to read out, sampled in CHECK
//   fifo_valid/fifo_data  FIFO read side, {rsvd[31:27], type[26:24], num[23:0]}
//   fifo_ready            registered pop strobe, high only in IDLE
//   ro_req/ro_type/ro_num/ro_chan_mask  readout request and its latched payload
//   ro_ack, ro_done       readout engine handshake (ro_done is a 1-cycle pulse)
//   err_clear             clears sticky errors and the expected-number state
//   evt_count             events fully read out (wraps)
//   drop_count            events dropped (saturates)
//   seq_err/fmt_err/timeout_err  sticky error flags
//   state[3:0]            one-hot {WAIT_DONE, REQUEST, CHECK, IDLE}
// ---------------------------------------------------------------------------
module acq_event_reader #(
    parameter logic [31:0] TIMEOUT   = 32'd4000000,
    parameter bit          FIRST_ANY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  chan_en,
    input  logic        fifo_valid,
    input  logic [31:0] fifo_data,
    output logic        fifo_ready,
    output logic        ro_req,
    output logic [2:0]  ro_type,
    output logic [23:0] ro_num,
    output logic [4:0]  ro_chan_mask,
    input  logic        ro_ack,
    input  logic        ro_done,
    input  logic        err_clear,
    output logic [31:0] evt_count,
    output logic [15:0] drop_count,
    output logic        seq_err,
    output logic        fmt_err,
    output logic        timeout_err,
    output logic [3:0]  state
);

    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_CHECK   = 4'b0010;
    localparam logic [3:0] ST_REQUEST = 4'b0100;
    localparam logic [3:0] ST_WAIT    = 4'b1000;

    localparam logic [31:0] TMO_LAST  = TIMEOUT - 32'd1;
    localparam logic [15:0] DROP_MAX  = 16'hFFFF;

    logic [3:0]  state_q,       state_d;
    logic        fifo_ready_q,  fifo_ready_d;
    logic        ro_req_q,      ro_req_d;
    logic [2:0]  type_q,        type_d;
    logic [23:0] num_q,         num_d;
    logic        rsvd_q,        rsvd_d;
    logic [4:0]  mask_q,        mask_d;
    logic [23:0] exp_num_q,     exp_num_d;
    logic        exp_valid_q,   exp_valid_d;
    logic [31:0] evt_count_q,   evt_count_d;
    logic [15:0] drop_count_q,  drop_count_d;
    logic        seq_err_q,     seq_err_d;
    logic        fmt_err_q,     fmt_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] tmo_cnt_q,     tmo_cnt_d;

    // Event classification from the latched word
    logic        fmt_bad_c;
    logic        exp_check_c;
    logic [23:0] exp_ref_c;

    always_comb begin
        fmt_bad_c   = rsvd_q || (type_q == 3'd0) || (type_q > 3'd3);
        // With FIRST_ANY cleared, an unset expectation means "expect 0"
        exp_check_c = exp_valid_q || !FIRST_ANY;
        exp_ref_c   = exp_valid_q ? exp_num_q : 24'd0;
    end

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        num_d         = num_q;
        rsvd_d        = rsvd_q;
        mask_d        = mask_q;
        exp_num_d     = exp_num_q;
        exp_valid_d   = exp_valid_q;
        evt_count_d   = evt_count_q;
        drop_count_d  = drop_count_q;
        seq_err_d     = seq_err_q;
        fmt_err_d     = fmt_err_q;
        timeout_err_d = timeout_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        fifo_ready_d  = 1'b0;
        ro_req_d      = 1'b0;

        // Clear first so that an error raised below in the same cycle wins
        if (err_clear) begin
            seq_err_d     = 1'b0;
            fmt_err_d     = 1'b0;
            timeout_err_d = 1'b0;
            exp_valid_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fifo_valid && fifo_ready_q) begin
                    type_d  = fifo_data[26:24];
                    num_d   = fifo_data[23:0];
                    rsvd_d  = |fifo_data[31:27];
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (fmt_bad_c) begin
                    fmt_err_d = 1'b1;
                    if (drop_count_q != DROP_MAX) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    // Mismatch is flagged but the event is still read out
                    if (exp_check_c && (num_q != exp_ref_c)) begin
                        seq_err_d = 1'b1;
                    end
                    exp_num_d   = num_q + 24'd1;
                    exp_valid_d = 1'b1;
                    mask_d      = chan_en;
                    if (chan_en == 5'd0) begin
                        evt_count_d = evt_count_q + 32'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_REQUEST;
                    end
                end
            end

            ST_REQUEST: begin
                if (ro_ack) begin
                    tmo_cnt_d = 32'd0;
                    if (ro_done) begin
                        evt_count_d = evt_count_q + 32'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (ro_done) begin
                    evt_count_d = evt_count_q + 32'd1;
                    state_d     = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    if (drop_count_q != DROP_MAX) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes registered from the upcoming state so they align with it
        fifo_ready_d = (state_d == ST_IDLE);
        ro_req_d     = (state_d == ST_REQUEST);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fifo_ready_q  <= 1'b0;
            ro_req_q      <= 1'b0;
            type_q        <= 3'd0;
            num_q         <= 24'd0;
            rsvd_q        <= 1'b0;
            mask_q        <= 5'd0;
            exp_num_q     <= 24'd0;
            exp_valid_q   <= 1'b0;
            evt_count_q   <= 32'd0;
            drop_count_q  <= 16'd0;
            seq_err_q     <= 1'b0;
            fmt_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            fifo_ready_q  <= fifo_ready_d;
            ro_req_q      <= ro_req_d;
            type_q        <= type_d;
            num_q         <= num_d;
            rsvd_q        <= rsvd_d;
            mask_q        <= mask_d;
            exp_num_q     <= exp_num_d;
            exp_valid_q   <= exp_valid_d;
            evt_count_q   <= evt_count_d;
            drop_count_q  <= drop_count_d;
            seq_err_q     <= seq_err_d;
            fmt_err_q     <= fmt_err_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign state        = state_q;
    assign fifo_ready   = fifo_ready_q;
    assign ro_req       = ro_req_q;
    assign ro_type      = type_q;
    assign ro_num       = num_q;
    assign ro_chan_mask = mask_q;
    assign evt_count    = evt_count_q;
    assign drop_count   = drop_count_q;
    assign seq_err      = seq_err_q;
    assign fmt_err      = fmt_err_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_acq_event_reader.sv
// ---------------------------------------------------------------------------
// tb_acq_event_reader
// Directed bench for acq_event_reader with a short readout timeout.
// ---------------------------------------------------------------------------
module tb_acq_event_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  chan_en;
    logic        fifo_valid;
    logic [31:0] fifo_data;
    logic        fifo_ready;
    logic        ro_req;
    logic [2:0]  ro_type;
    logic [23:0] ro_num;
    logic [4:0]  ro_chan_mask;
    logic        ro_ack;
    logic        ro_done;
    logic        err_clear;
    logic [31:0] evt_count;
    logic [15:0] drop_count;
    logic        seq_err;
    logic        fmt_err;
    logic        timeout_err;
    logic [3:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt = 0;
    int req_cnt = 0;
    int r0;

    acq_event_reader #(
        .TIMEOUT   (32'd16),
        .FIRST_ANY (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .chan_en      (chan_en),
        .fifo_valid   (fifo_valid),
        .fifo_data    (fifo_data),
        .fifo_ready   (fifo_ready),
        .ro_req       (ro_req),
        .ro_type      (ro_type),
        .ro_num       (ro_num),
        .ro_chan_mask (ro_chan_mask),
        .ro_ack       (ro_ack),
        .ro_done      (ro_done),
        .err_clear    (err_clear),
        .evt_count    (evt_count),
        .drop_count   (drop_count),
        .seq_err      (seq_err),
        .fmt_err      (fmt_err),
        .timeout_err  (timeout_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Transfer and request observers
    always @(posedge clk) if (fifo_valid && fifo_ready) pop_cnt++;
    always @(posedge ro_req) req_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
    endtask

    // Offer one word; returns one cycle after the transfer (DUT in CHECK)
    task automatic send_word(input logic [31:0] word, input logic [4:0] chan);
        int k;
        chan_en    = chan;
        fifo_data  = word;
        fifo_valid = 1'b1;
        k = 0;
        while (!fifo_ready && k < 50) begin
            step();
            k++;
        end
        if (!fifo_ready) begin
            check_val("pop_wait", 32'(fifo_ready), 32'd1);
            fifo_valid = 1'b0;
        end else begin
            step();
            fifo_valid = 1'b0;
            check_val("ready_drop", 32'(fifo_ready), 32'd0);
            check_val("state_check", 32'(state), 32'h2);
        end
    endtask

    // Readout engine: ack after ack_dly cycles, done done_dly cycles after ack
    // (0 = with ack, negative = never)
    task automatic serve(input int ack_dly, input int done_dly,
                         input logic [2:0] et, input logic [23:0] en, input logic [4:0] em);
        int k;
        k = 0;
        while (!ro_req && k < 20) begin
            step();
            k++;
        end
        if (!ro_req) begin
            check_val("req_wait", 32'(ro_req), 32'd1);
            return;
        end
        check_val("ro_type", 32'(ro_type), 32'(et));
        check_val("ro_num", 32'(ro_num), 32'(en));
        check_val("ro_mask", 32'(ro_chan_mask), 32'(em));
        repeat (ack_dly) step();
        if (ack_dly > 0) begin
            check_val("req_hold", 32'(ro_req), 32'd1);
            check_val("num_hold", 32'(ro_num), 32'(en));
        end
        ro_ack = 1'b1;
        if (done_dly == 0) ro_done = 1'b1;
        step();
        ro_ack  = 1'b0;
        ro_done = 1'b0;
        check_val("req_drop", 32'(ro_req), 32'd0);
        if (done_dly > 0) begin
            repeat (done_dly - 1) step();
            ro_done = 1'b1;
            step();
            ro_done = 1'b0;
        end
        if (done_dly >= 0) check_val("state_idle", 32'(state), 32'h1);
    endtask

    initial begin
        reset      = 1'b1;
        chan_en    = 5'd0;
        fifo_valid = 1'b0;
        fifo_data  = 32'd0;
        ro_ack     = 1'b0;
        ro_done    = 1'b0;
        err_clear  = 1'b0;
        #1;
        check_val("rst_state", 32'(state), 32'h1);
        check_val("rst_ready", 32'(fifo_ready), 32'd0);
        check_val("rst_req", 32'(ro_req), 32'd0);
        check_val("rst_evt", evt_count, 32'd0);
        check_val("rst_drop", 32'(drop_count), 32'd0);
        check_val("rst_errs", {29'd0, seq_err, fmt_err, timeout_err}, 32'd0);
        step();
        step();
        reset = 1'b0;
        check_val("ready_hold", 32'(fifo_ready), 32'd0);
        step();
        check_val("ready_up", 32'(fifo_ready), 32'd1);

        // Single event, slow readout
        send_word(32'h0100_0005, 5'h1F);
        serve(2, 3, 3'd1, 24'h5, 5'h1F);
        check_val("t1_evt", evt_count, 32'd1);
        check_val("t1_errs", {29'd0, seq_err, fmt_err, timeout_err}, 32'd0);
        check_val("t1_pops", 32'(pop_cnt), 32'd1);
        check_val("t1_reqs", 32'(req_cnt), 32'd1);

        // Continuity: 7, 8 ok, 10 skips, 11 resyncs
        pulse_clear();
        send_word(32'h0100_0007, 5'h03);
        serve(0, 1, 3'd1, 24'h7, 5'h03);
        check_val("t2_seq7", 32'(seq_err), 32'd0);
        send_word(32'h0100_0008, 5'h03);
        serve(0, 1, 3'd1, 24'h8, 5'h03);
        check_val("t2_seq8", 32'(seq_err), 32'd0);
        send_word(32'h0100_000A, 5'h03);
        serve(0, 1, 3'd1, 24'hA, 5'h03);
        check_val("t2_seq10", 32'(seq_err), 32'd1);
        send_word(32'h0100_000B, 5'h03);
        serve(0, 0, 3'd1, 24'hB, 5'h03);
        check_val("t2_seq11", 32'(seq_err), 32'd1);
        check_val("t2_evt", evt_count, 32'd5);
        pulse_clear();
        check_val("t2_clear", 32'(seq_err), 32'd0);

        // Format errors: reserved bit, illegal type
        r0 = req_cnt;
        send_word(32'h0800_0001, 5'h1F);
        step();
        check_val("t3_fmt1", 32'(fmt_err), 32'd1);
        check_val("t3_drop1", 32'(drop_count), 32'd1);
        send_word(32'h0600_000C, 5'h1F);
        step();
        check_val("t3_drop2", 32'(drop_count), 32'd2);
        check_val("t3_noreq", 32'(req_cnt - r0), 32'd0);
        check_val("t3_evt", evt_count, 32'd5);
        check_val("t3_seq", 32'(seq_err), 32'd0);

        // Number wrap and empty channel mask
        pulse_clear();
        check_val("t4_fmtclr", 32'(fmt_err), 32'd0);
        send_word(32'h02FF_FFFF, 5'h10);
        serve(0, 1, 3'd2, 24'hFFFFFF, 5'h10);
        send_word(32'h0300_0000, 5'h01);
        serve(0, 1, 3'd3, 24'h000000, 5'h01);
        check_val("t4_wrap", 32'(seq_err), 32'd0);
        r0 = req_cnt;
        send_word(32'h0100_0001, 5'h00);
        step();
        check_val("t4_nochan_st", 32'(state), 32'h1);
        check_val("t4_nochan_req", 32'(req_cnt - r0), 32'd0);
        check_val("t4_evt", evt_count, 32'd8);
        check_val("t4_seq", 32'(seq_err), 32'd0);

        // Readout timeout after 16 WAIT_DONE cycles
        send_word(32'h0100_0002, 5'h03);
        serve(0, -1, 3'd1, 24'h2, 5'h03);
        repeat (15) step();
        check_val("t5_wait16", 32'(state), 32'h8);
        check_val("t5_noerr", 32'(timeout_err), 32'd0);
        step();
        check_val("t5_tmo", 32'(timeout_err), 32'd1);
        check_val("t5_idle", 32'(state), 32'h1);
        check_val("t5_drop", 32'(drop_count), 32'd3);
        check_val("t5_evt", evt_count, 32'd8);
        send_word(32'h0100_0003, 5'h01);
        serve(0, 1, 3'd1, 24'h3, 5'h01);
        check_val("t5_next", evt_count, 32'd9);
        check_val("t5_seq", 32'(seq_err), 32'd0);

        // Asynchronous reset during WAIT_DONE
        send_word(32'h0100_0004, 5'h01);
        serve(0, -1, 3'd1, 24'h4, 5'h01);
        step();
        step();
        check_val("t6_inwait", 32'(state), 32'h8);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_state", 32'(state), 32'h1);
        check_val("t6_req", 32'(ro_req), 32'd0);
        check_val("t6_evt", evt_count, 32'd0);
        check_val("t6_drop", 32'(drop_count), 32'd0);
        check_val("t6_errs", {29'd0, seq_err, fmt_err, timeout_err}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // err_clear in the same cycle as a sequence mismatch
        send_word(32'h0100_0014, 5'h01);
        serve(0, 1, 3'd1, 24'h14, 5'h01);
        send_word(32'h0100_0019, 5'h01);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_val("t7_seqwins", 32'(seq_err), 32'd1);
        serve(0, 1, 3'd1, 24'h19, 5'h01);
        check_val("t7_evt", evt_count, 32'd2);
        check_val("total_pops", 32'(pop_cnt), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
